// File: rtl/spart_rx.sv
// SPART receiver: 16x oversampled 8N1 UART receive path.
// Delivers bytes with rda/ack handshake, frame and overrun flags.
module spart_rx #(
   parameter int unsigned DIV_4800  = 1302,
   parameter int unsigned DIV_9600  = 651,
   parameter int unsigned DIV_19200 = 326,
   parameter int unsigned DIV_38400 = 163
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic [1:0] br_cfg,
   input  logic       rd_ack,
   output logic [7:0] rx_data,
   output logic       rda,
   output logic       frame_err,
   output logic       overrun
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state;
   logic        rx_s1;
   logic        rx_s2;
   logic        rx_prev;
   logic [15:0] cnt;
   logic [15:0] reload;
   logic        tick;
   logic        fall;
   logic        restart;
   logic [3:0]  smp;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;

   // Two-flop synchronizer plus previous-value flop for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rxd;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Select the reload value from the baud configuration
   always_comb begin
      reload = 16'(DIV_4800 - 1);
      unique case (br_cfg)
         2'b00: reload = 16'(DIV_4800 - 1);
         2'b01: reload = 16'(DIV_9600 - 1);
         2'b10: reload = 16'(DIV_19200 - 1);
         2'b11: reload = 16'(DIV_38400 - 1);
      endcase
   end

   assign fall    = rx_prev & ~rx_s2;
   assign restart = (state == IDLE) && fall;
   assign tick    = (cnt == 16'd0);

   // Oversample tick generator; br_cfg only matters at reload time
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= 16'd0;
      else if (restart || tick)
         cnt <= reload;
      else
         cnt <= cnt - 16'd1;
   end

   // Receive FSM with registered byte, flags and handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         smp       <= 4'd0;
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         rx_data   <= 8'h00;
         rda       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (rd_ack && rda) begin
            rda     <= 1'b0;
            overrun <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (fall) begin
                  smp   <= 4'd0;
                  state <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (smp == 4'd7) begin
                     smp     <= 4'd0;
                     bit_cnt <= 3'd0;
                     state   <= rx_s2 ? IDLE : DATA;
                  end else begin
                     smp <= smp + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (smp == 4'd15) begin
                     shreg[bit_cnt] <= rx_s2;
                     smp            <= 4'd0;
                     bit_cnt        <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7)
                        state <= STOP;
                  end else begin
                     smp <= smp + 4'd1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (smp == 4'd15) begin
                     rx_data   <= shreg;
                     rda       <= 1'b1;
                     frame_err <= ~rx_s2;
                     overrun   <= rda & ~rd_ack;
                     smp       <= 4'd0;
                     state     <= IDLE;
                  end else begin
                     smp <= smp + 4'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spart_rx.sv
// Directed testbench for spart_rx with reduced divisors.
// Frames are driven cycle-accurately so completion timing is known.
module tb_spart_rx;

   localparam int D0 = 40;
   localparam int D1 = 20;
   localparam int D2 = 10;
   localparam int D3 = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic [1:0] br_cfg = 2'b01;
   logic       rd_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rda;
   logic       frame_err;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   spart_rx #(
      .DIV_4800(D0),
      .DIV_9600(D1),
      .DIV_19200(D2),
      .DIV_38400(D3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rxd(rxd),
      .br_cfg(br_cfg),
      .rd_ack(rd_ack),
      .rx_data(rx_data),
      .rda(rda),
      .frame_err(frame_err),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ack_pulse();
      @(posedge clk);
      #1 rd_ack = 1'b1;
      @(posedge clk);
      #1 rd_ack = 1'b0;
   endtask

   // Falling edge at cycle 0; the stop-sample tick is consumed at
   // the edge 152*d+3 cycles later, so outputs change right after it.
   task automatic send_frame(input logic [7:0] data, input logic stop,
                             input int d, input bit ack_end,
                             input bit tchk, input logic exp_pre,
                             input int abort_bit);
      logic [9:0] bits;
      int idx;
      bits = {stop, data, 1'b0};
      @(posedge clk);
      #1 rxd = 1'b0;
      for (int i = 1; i < 160 * d; i++) begin
         @(posedge clk);
         #1;
         idx = i / (16 * d);
         if (abort_bit >= 0 && idx == abort_bit &&
             (i % (16 * d)) == 8 * d) begin
            rst = 1'b0;
            #1;
            return;
         end
         rxd = bits[idx];
         rd_ack = ack_end && (i == 152 * d + 2);
         if (tchk && i == 152 * d + 2)
            check("rda_before_stop_tick", {7'd0, rda}, {7'd0, exp_pre});
         if (tchk && i == 152 * d + 3)
            check("rda_after_stop_tick", {7'd0, rda}, 8'h01);
      end
      rd_ack = 1'b0;
      wait_cyc(1);
   endtask

   initial begin
      wait_cyc(5);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rda", {7'd0, rda}, 8'h00);
      check("rst_frame_err", {7'd0, frame_err}, 8'h00);
      check("rst_overrun", {7'd0, overrun}, 8'h00);
      rst = 1'b1;
      wait_cyc(20);

      br_cfg = 2'b01;
      rxd = 1'b0;
      wait_cyc(10);
      rxd = 1'b1;
      wait_cyc(16 * D1);
      check("glitch_rda", {7'd0, rda}, 8'h00);
      check("glitch_rx_data", rx_data, 8'h00);

      send_frame(8'h55, 1'b1, D1, 1'b0, 1'b1, 1'b0, -1);
      check("b55_rx_data", rx_data, 8'h55);
      check("b55_rda", {7'd0, rda}, 8'h01);
      check("b55_frame_err", {7'd0, frame_err}, 8'h00);
      check("b55_overrun", {7'd0, overrun}, 8'h00);
      ack_pulse();
      check("b55_ack_rda", {7'd0, rda}, 8'h00);
      check("b55_ack_data_kept", rx_data, 8'h55);
      ack_pulse();
      check("ack_idle_rda", {7'd0, rda}, 8'h00);
      wait_cyc(20);

      send_frame(8'hAA, 1'b1, D1, 1'b0, 1'b0, 1'b0, -1);
      check("bAA_rx_data", rx_data, 8'hAA);
      check("bAA_overrun", {7'd0, overrun}, 8'h00);
      wait_cyc(20);
      send_frame(8'hC3, 1'b1, D1, 1'b0, 1'b0, 1'b0, -1);
      check("bC3_rx_data", rx_data, 8'hC3);
      check("bC3_rda", {7'd0, rda}, 8'h01);
      check("bC3_overrun", {7'd0, overrun}, 8'h01);
      ack_pulse();
      check("bC3_ack_rda", {7'd0, rda}, 8'h00);
      check("bC3_ack_overrun", {7'd0, overrun}, 8'h00);
      wait_cyc(20);

      send_frame(8'h11, 1'b1, D1, 1'b0, 1'b0, 1'b0, -1);
      wait_cyc(20);
      send_frame(8'h22, 1'b1, D1, 1'b0, 1'b0, 1'b0, -1);
      check("b22_overrun", {7'd0, overrun}, 8'h01);
      wait_cyc(20);
      send_frame(8'h7E, 1'b1, D1, 1'b1, 1'b1, 1'b1, -1);
      check("b7E_rx_data", rx_data, 8'h7E);
      check("b7E_rda", {7'd0, rda}, 8'h01);
      check("b7E_overrun", {7'd0, overrun}, 8'h00);
      ack_pulse();
      wait_cyc(20);

      send_frame(8'h3C, 1'b0, D1, 1'b0, 1'b0, 1'b0, -1);
      check("b3C_rx_data", rx_data, 8'h3C);
      check("b3C_rda", {7'd0, rda}, 8'h01);
      check("b3C_frame_err", {7'd0, frame_err}, 8'h01);
      ack_pulse();
      wait_cyc(200 * D1);
      check("low_level_no_byte", {7'd0, rda}, 8'h00);
      rxd = 1'b1;
      wait_cyc(20);
      send_frame(8'h96, 1'b1, D1, 1'b0, 1'b0, 1'b0, -1);
      check("b96_rx_data", rx_data, 8'h96);
      check("b96_frame_err", {7'd0, frame_err}, 8'h00);
      ack_pulse();
      wait_cyc(20);

      br_cfg = 2'b11;
      wait_cyc(20);
      send_frame(8'h5A, 1'b1, D3, 1'b0, 1'b1, 1'b0, -1);
      check("b5A_rx_data", rx_data, 8'h5A);
      check("b5A_rda", {7'd0, rda}, 8'h01);
      wait_cyc(20);
      send_frame(8'hF0, 1'b1, D3, 1'b0, 1'b0, 1'b0, 4);
      check("midrst_rx_data", rx_data, 8'h00);
      check("midrst_rda", {7'd0, rda}, 8'h00);
      check("midrst_frame_err", {7'd0, frame_err}, 8'h00);
      check("midrst_overrun", {7'd0, overrun}, 8'h00);
      rxd = 1'b1;
      wait_cyc(5);
      rst = 1'b1;
      wait_cyc(200 * D3);
      check("post_rst_no_byte", {7'd0, rda}, 8'h00);
      send_frame(8'h81, 1'b1, D3, 1'b0, 1'b0, 1'b0, -1);
      check("b81_rx_data", rx_data, 8'h81);
      check("b81_rda", {7'd0, rda}, 8'h01);
      check("b81_frame_err", {7'd0, frame_err}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 Parameter DIV_4800, default 1302; 16x-oversample divisor at 100 MHz for br_cfg=00.
REQ-002 Parameter DIV_9600, default 651; divisor for br_cfg=01.
REQ-003 Parameter DIV_19200, default 326; divisor for br_cfg=10.
REQ-004 Parameter DIV_38400, default 163; divisor for br_cfg=11.
REQ-005 clk  input  1  system clock (100 MHz); the block's only clock.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-008 br_cfg  input  2  baud select (00=4800, 01=9600, 10=19200, 11=38400).
REQ-009 rd_ack  input  1  one-cycle pulse from the consumer; acknowledges rx_data.
REQ-010 rx_data  output  8  last received byte.
REQ-011 rda  output  1  receive data available, held until acknowledged.
REQ-012 frame_err  output  1  stop bit of the byte in rx_data sampled low.
REQ-013 overrun  output  1  byte completed while rda was already set.

Function
REQ-014 rxd passes through a 2-flop synchronizer; both flops reset to 1; all logic uses the synchronized value.
REQ-015 Tick generator: down-counter reloads with selected divisor minus 1; one-cycle tick when it reaches 0.
REQ-016 br_cfg is sampled at each reload; a change takes effect at the next reload, with no tick glitch.
REQ-017 FSM states: IDLE, START, DATA, STOP.
REQ-018 IDLE: a synchronized falling edge (prior 1, now 0) clears the sample counter and the tick counter, then enters START.
REQ-019 START: on the 8th tick, if rxd=0, clear the sample counter and enter DATA; if rxd=1, the event is a glitch; return to IDLE with no output change.
REQ-020 DATA: on every 16th tick, shift rxd into bit position [bit_cnt], LSB first; after 8 bits, enter STOP.
REQ-021 STOP: on the 16th tick, load rx_data from the shift register, set rda, set frame_err to the inverse of rxd, return to IDLE.
REQ-022 rda, frame_err, rx_data and overrun update one clk after the stop-sample tick.
REQ-023 A framing-error byte is still delivered; IDLE then waits for a new 1->0 edge, never a low level.
REQ-024 rd_ack with rda=1 clears rda and overrun on the next clk; rd_ack with rda=0 has no effect.
REQ-025 Byte completion with rda=1 and no rd_ack in the same cycle: rx_data is overwritten, rda stays 1, overrun set.
REQ-026 Byte completion and rd_ack in the same cycle: new byte loaded, rda stays 1, overrun cleared.
REQ-027 rx_data is stable whenever rda=1, except on overwrite per REQ-025/026.
REQ-028 The bit counter is 3 bits and the sample counter is 4 bits; neither wraps outside its state.

Reset
REQ-029 rst=0 asynchronously forces: FSM=IDLE, all counters 0, shift register 0, rx_data=8'h00, rda=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-030 Reset asserted mid-frame discards the partial byte; after release, the block waits for a fresh falling edge.

Verification
REQ-031 br_cfg=01, send frame with data 0x55 (bit time 104.17 us), stop=1 -> rx_data=8'h55, rda=1, frame_err=0 within 1 clk after the stop-sample tick.
REQ-032 Send 0xAA at br_cfg=01, no rd_ack, then send 0xC3 -> rx_data=8'hC3, rda=1, overrun=1; then pulse rd_ack -> rda=0, overrun=0.
REQ-033 Send 0x3C with stop bit held 0 -> rx_data=8'h3C, rda=1, frame_err=1; no new byte until rxd returns high and falls again.
REQ-034 rxd low pulse of 3 us while idle at br_cfg=01 -> FSM returns to IDLE, rda stays 0.
REQ-035 br_cfg=11, send 0x5A at 26.04 us/bit -> rx_data=8'h5A, rda=1; assert rst=0 during the 4th data bit of a following frame -> all outputs at reset values immediately.
REQ-036 Assert rd_ack in the exact cycle a byte completes with rda=1 -> rda=1, new data loaded, overrun=0.
